// File: rtl/cfglut_kd.sv
// cfglut_kd: runtime-reloadable K-input LUT with a serial CE-gated config shift port,
// cascade output, optional registered O/LO, and reload progress tracking.
module cfglut_kd #(
  parameter int K = 5,
  parameter logic [2**K-1:0] INIT = '0,
  parameter bit REG_OUT = 1'b0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         CE,
  input  logic         CDI,
  input  logic [K-1:0] I,
  output logic         O,
  output logic         LO,
  output logic         CDO,
  output logic         CFG_BUSY,
  output logic         CFG_DONE
);
  localparam int N = 2**K;
  if (K < 3 || K > 6) begin : g_bad_k
    $error("cfglut_kd: K must be in 3..6");
  end
  logic [N-1:0] t;
  logic [K-1:0] cnt;
  logic o_c, lo_c;
  assign o_c = t[I];
  assign lo_c = t[{1'b0, I[K-2:0]}];
  assign CDO = t[N-1];
  assign CFG_BUSY = |cnt;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      t <= INIT;
      cnt <= '0;
      CFG_DONE <= 1'b0;
    end else begin
      if (CE) begin
        t <= {t[N-2:0], CDI};
        cnt <= cnt + 1'b1;
      end
      CFG_DONE <= CE && (&cnt);
    end
  // Registered mode samples every edge, independent of CE, from the pre-edge table.
  if (REG_OUT) begin : g_reg
    always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
        O <= INIT[0];
        LO <= INIT[0];
      end else begin
        O <= o_c;
        LO <= lo_c;
      end
  end else begin : g_comb
    assign O = o_c;
    assign LO = lo_c;
  end
endmodule
